// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared constants and state encoding for the bit-serial subtractor
package serial_sub_pkg;
   localparam int DEF_WIDTH = 8;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   typedef enum logic [1:0] {ST_IDLE = S_IDLE, ST_RUN = S_RUN, ST_DONE = S_DONE} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - bin cell
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b through one full_subtractor and a borrow flop
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);
   localparam int CW = $clog2(WIDTH);
   state_t state, state_n;
   logic [WIDTH-1:0] a_sh, b_sh, d_nx;
   logic [WIDTH-2:0] d_sh;
   logic [CW-1:0] cnt;
   logic br, d, bo, last;
   full_subtractor u_cell (.x(a_sh[0]), .y(b_sh[0]), .bin(br), .d(d), .bout(bo));
   assign last = cnt == CW'(WIDTH - 1);
   // d_sh keeps only the WIDTH-1 bits already produced; the final bit joins on the last edge
   assign d_nx = {d, d_sh};
   assign busy = state != ST_IDLE;
   assign done = state == ST_DONE;
   always_comb begin
      state_n = ST_IDLE;
      case (state)
         ST_IDLE: state_n = start ? ST_RUN : ST_IDLE;
         ST_RUN:  state_n = last ? ST_DONE : ST_RUN;
         default: state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         d_sh       <= '0;
         cnt        <= '0;
         br         <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= 1'b0;
            cnt  <= '0;
         end else if (state == ST_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= d_nx[WIDTH-1:1];
            br   <= bo;
            cnt  <= cnt + CW'(1);
            if (last) begin
               diff       <= d_nx;
               borrow_out <= bo;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table, directed and random checks for serial_subtractor (WIDTH 8 and 13) and full_subtractor
module tb_serial_subtractor;
   logic clk = 0, rst_n = 0;
   logic s8 = 0, s13 = 0;
   logic [7:0] a8 = 0, b8 = 0, df8;
   logic [12:0] a13 = 0, b13 = 0, df13;
   logic bz8, dn8, bo8, bz13, dn13, bo13;
   logic fx = 0, fy = 0, fb = 0, fd, fbo;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
      .busy(bz8), .done(dn8), .diff(df8), .borrow_out(bo8));
   serial_subtractor #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .start(s13), .a(a13), .b(b13),
      .busy(bz13), .done(dn13), .diff(df13), .borrow_out(bo13));
   full_subtractor u_fs (.x(fx), .y(fy), .bin(fb), .d(fd), .bout(fbo));

   typedef struct {logic x, y, bin, d, bo;} fs_vec_t;
   typedef struct {logic [7:0] a, b, diff; logic bo;} op_vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic cur_busy(input bit w13);
      return w13 ? bz13 : bz8;
   endfunction
   function automatic logic cur_done(input bit w13);
      return w13 ? dn13 : dn8;
   endfunction
   function automatic logic [12:0] cur_diff(input bit w13);
      return w13 ? df13 : {5'b0, df8};
   endfunction
   function automatic logic cur_bo(input bit w13);
      return w13 ? bo13 : bo8;
   endfunction

   task automatic drive(input bit w13, input logic st, input logic [12:0] av, input logic [12:0] bv);
      if (w13) begin s13 = st; a13 = av; b13 = bv; end
      else begin s8 = st; a8 = av[7:0]; b8 = bv[7:0]; end
   endtask

   // full operation with latency, busy length, hold and single-pulse checks against plain arithmetic
   task automatic op(input bit w13, input logic [12:0] av, input logic [12:0] bv, input bit tog);
      int wd = w13 ? 13 : 8;
      int mask = (1 << wd) - 1;
      int dv = int'(av) & mask;
      int ref_d = dv - (int'(bv) & mask);
      logic [12:0] hd = cur_diff(w13);
      logic hb = cur_bo(w13);
      logic st = 1'b0;
      int n = 0, bc;
      bit held = 1;
      while (cur_busy(w13) && n < 100) begin tick(); n++; end
      chk("idle_wait", {31'b0, cur_busy(w13)}, 0);
      drive(w13, 1'b1, av, bv);
      tick();
      drive(w13, 1'b0, 13'($urandom), 13'($urandom));
      bc = cur_busy(w13) ? 1 : 0;
      n = 0;
      while (!cur_done(w13) && n < 40) begin
         if (cur_diff(w13) !== hd || cur_bo(w13) !== hb) held = 0;
         tick();
         n++;
         if (cur_busy(w13)) bc++;
         if (tog) begin st = ~st; drive(w13, st, 13'($urandom), 13'($urandom)); end
      end
      drive(w13, 1'b0, 13'($urandom), 13'($urandom));
      chk("latency", n, wd);
      chk("busy_len", bc, wd + 1);
      chk("hold", {31'b0, held}, 1);
      chk("diff", {19'b0, cur_diff(w13)}, ref_d & mask);
      chk("borrow", {31'b0, cur_bo(w13)}, {31'b0, ref_d < 0});
      tick();
      chk("done_pulse", {30'b0, cur_done(w13), cur_busy(w13)}, 0);
   endtask

   initial begin
      fs_vec_t fsv[8];
      op_vec_t ov[7];
      int dt[$];
      int n;
      fsv = '{'{0,0,0,0,0}, '{0,0,1,1,1}, '{0,1,0,1,1}, '{0,1,1,0,1},
              '{1,0,0,1,0}, '{1,0,1,0,0}, '{1,1,0,0,0}, '{1,1,1,1,1}};
      ov  = '{'{8'h5A, 8'h3C, 8'h1E, 0}, '{8'h00, 8'h01, 8'hFF, 1}, '{8'h80, 8'h80, 8'h00, 0},
              '{8'hFF, 8'hFF, 8'h00, 0}, '{8'h00, 8'hFF, 8'h01, 1}, '{8'hFF, 8'h00, 8'hFF, 0},
              '{8'h01, 8'h02, 8'hFF, 1}};
      for (int i = 0; i < 8; i++) begin
         {fx, fy, fb} = {fsv[i].x, fsv[i].y, fsv[i].bin};
         #1;
         chk($sformatf("fs_%0d", i), {30'b0, fd, fbo}, {30'b0, fsv[i].d, fsv[i].bo});
      end
      repeat (2) tick();
      chk("rst8", {22'b0, bz8, dn8, df8, bo8}, 0);
      chk("rst13", {17'b0, bz13, dn13, df13, bo13}, 0);
      rst_n = 1;
      tick();
      for (int i = 0; i < 7; i++) begin
         op(0, {5'b0, ov[i].a}, {5'b0, ov[i].b}, 0);
         chk($sformatf("tbl_%0d", i), {23'b0, df8, bo8}, {23'b0, ov[i].diff, ov[i].bo});
      end
      // start held high: completions every WIDTH+2 cycles
      drive(0, 1'b1, 13'h0FF, 13'h00F);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (dn8) begin
            dt.push_back(i);
            chk("hold_hi_diff", {23'b0, df8, bo8}, {23'b0, 8'hF0, 1'b0});
         end
      end
      drive(0, 1'b0, 0, 0);
      chk("hold_hi_count", dt.size(), 3);
      if (dt.size() == 3) begin
         chk("hold_hi_gap1", dt[1] - dt[0], 10);
         chk("hold_hi_gap2", dt[2] - dt[1], 10);
      end
      repeat (3) tick();
      op(0, 13'h0C3, 13'h011, 1);
      op(0, 13'h011, 13'h0C3, 1);
      // reset during RUN cycle 4
      drive(0, 1'b1, 13'h0C3, 13'h011);
      tick();
      drive(0, 1'b0, 0, 0);
      repeat (4) tick();
      chk("pre_rst_busy", {31'b0, bz8}, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_out", {22'b0, bz8, dn8, df8, bo8}, 0);
      tick();
      rst_n = 1;
      n = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (dn8 || bz8) n++; end
      chk("no_done_after_rst", n, 0);
      op(0, 13'h010, 13'h020, 0);
      chk("post_rst", {23'b0, df8, bo8}, {23'b0, 8'hF0, 1'b1});
      for (int i = 0; i < 1000; i++) op(0, 13'($urandom), 13'($urandom), i % 7 == 0);
      for (int i = 0; i < 1000; i++) op(1, 13'($urandom), 13'($urandom), i % 7 == 0);
      op(1, 13'h0000, 13'h1FFF, 0);
      chk("w13_edge", {18'b0, df13, bo13}, {18'b0, 13'h0001, 1'b1});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
